// File: rtl/door_pkg.sv
// door_pkg: shared types and default timing for the door sequencer.
//   door_state_t : FSM state encoding (also the value on the state port)
//   DEF_*        : default timing for a 100 MHz clk driving an SG-90 servo
//   POS_W        : width of the servo position word
package door_pkg;

  typedef enum logic [1:0] {
    CLOSED    = 2'd0,
    OPENING   = 2'd1,
    OPEN_HOLD = 2'd2,
    CLOSING   = 2'd3
  } door_state_t;

  localparam int unsigned DEF_FRAME_CYCLES = 2000000;  // 20 ms frame
  localparam int unsigned DEF_PULSE_MIN    = 100000;   // 1 ms pulse at pos 0
  localparam int unsigned DEF_PULSE_SPAN   = 100000;   // pos at fully open
  localparam int unsigned DEF_STEP         = 500;      // pos change per frame
  localparam int unsigned DEF_HOLD_FRAMES  = 250;      // 5 s open hold

  localparam int POS_W = 17;

endpackage

// File: rtl/servo_pwm.sv
// servo_pwm: servo frame timer and pulse generator.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   pos         : requested position, sampled once at the start of each frame
//   pwm_out     : registered servo pulse, PULSE_MIN+pos cycles wide per frame
//   frame_tick  : high during the last cycle of each frame
module servo_pwm
  import door_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = DEF_FRAME_CYCLES,
  parameter int unsigned PULSE_MIN    = DEF_PULSE_MIN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] pos,
  output logic             pwm_out,
  output logic             frame_tick
);

  localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] pos_lat_q, pos_lat_d;
  logic [POS_W-1:0] pos_sel;
  logic [31:0]      pulse_w;
  logic             pwm_q, pwm_d;

  always_comb begin
    frame_tick = (cnt_q == CNT_LAST);
    cnt_d      = frame_tick ? '0 : cnt_q + CNT_W'(1);
    // At count 0 the live pos is used and captured, so the whole frame
    // (including its first compare) sees one consistent width.
    pos_sel    = (cnt_q == '0) ? pos : pos_lat_q;
    pos_lat_d  = pos_sel;
    pulse_w    = PULSE_MIN + 32'(pos_sel);
    pwm_d      = (32'(cnt_q) < pulse_w);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      pos_lat_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pos_lat_q <= pos_lat_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/door_sequencer.sv
// door_sequencer: door-motion FSM ramping a servo position one step per frame,
// holding open for HOLD_FRAMES frames, then auto-closing.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   open_req    : request to open (open wins over close)
//   close_req   : request to close
//   obstacle    : obstacle sensor, honoured only when OBSTACLE_REOPEN_EN is
//                 defined (reopens while closing, extends/keeps the open hold)
//   pwm_out     : servo PWM
//   pos         : current position 0..PULSE_SPAN
//   state       : FSM state code (door_state_t)
//   busy        : high while OPENING or CLOSING
//   frame_tick  : one-cycle pulse at the last cycle of each frame
//
// state     | meaning
// CLOSED    | door shut, pos = 0, waiting for open_req
// OPENING   | pos rises by STEP each frame until PULSE_SPAN
// OPEN_HOLD | fully open, counting down HOLD_FRAMES frames
// CLOSING   | pos falls by STEP each frame until 0
module door_sequencer
  import door_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = DEF_FRAME_CYCLES,
  parameter int unsigned PULSE_MIN    = DEF_PULSE_MIN,
  parameter int unsigned PULSE_SPAN   = DEF_PULSE_SPAN,
  parameter int unsigned STEP         = DEF_STEP,
  parameter int unsigned HOLD_FRAMES  = DEF_HOLD_FRAMES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             open_req,
  input  logic             close_req,
  input  logic             obstacle,
  output logic             pwm_out,
  output logic [POS_W-1:0] pos,
  output logic [1:0]       state,
  output logic             busy,
  output logic             frame_tick
);

  localparam int AW     = POS_W + 1;
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [AW-1:0]     SPAN_A    = AW'(PULSE_SPAN);
  localparam logic [AW-1:0]     STEP_A    = AW'(STEP);
  localparam logic [POS_W-1:0]  SPAN_P    = POS_W'(PULSE_SPAN);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_FRAMES);

  door_state_t       state_q, state_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              busy_q, busy_d;
  logic              obs_en;

  logic [AW-1:0]     pos_up, pos_up_sat, pos_dn;
  logic [POS_W-1:0]  ramp_up, ramp_dn;

`ifdef OBSTACLE_REOPEN_EN
  assign obs_en = obstacle;
`else
  logic unused_obstacle;
  assign unused_obstacle = obstacle;
  assign obs_en = 1'b0;
`endif

  servo_pwm #(
    .FRAME_CYCLES (FRAME_CYCLES),
    .PULSE_MIN    (PULSE_MIN)
  ) u_pwm (
    .clk        (clk),
    .rst        (rst),
    .pos        (pos_q),
    .pwm_out    (pwm_out),
    .frame_tick (frame_tick)
  );

  // One extra bit of headroom so the step can never wrap before saturation.
  always_comb begin
    pos_up     = {1'b0, pos_q} + STEP_A;
    pos_up_sat = (pos_up > SPAN_A) ? SPAN_A : pos_up;
    pos_dn     = ({1'b0, pos_q} < STEP_A) ? '0 : {1'b0, pos_q} - STEP_A;
    ramp_up    = POS_W'(pos_up_sat);
    ramp_dn    = POS_W'(pos_dn);
  end

  // Any request that changes state takes priority over the frame ramp, so a
  // reversal never moves pos in the old direction on the same edge.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    hold_d  = hold_q;
    case (state_q)
      CLOSED: begin
        if (open_req) state_d = OPENING;
      end
      OPENING: begin
        if (close_req && !open_req) begin
          state_d = CLOSING;
        end else if (frame_tick) begin
          pos_d = ramp_up;
          if (ramp_up == SPAN_P) begin
            state_d = OPEN_HOLD;
            hold_d  = HOLD_LOAD;
          end
        end
      end
      OPEN_HOLD: begin
        if (open_req || obs_en) begin
          hold_d = HOLD_LOAD;
        end else if (close_req) begin
          state_d = CLOSING;
        end else if (frame_tick) begin
          if (hold_q <= HOLD_W'(1)) begin
            hold_d  = '0;
            state_d = CLOSING;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
      end
      CLOSING: begin
        if (open_req || obs_en) begin
          state_d = OPENING;
        end else if (frame_tick) begin
          pos_d = ramp_dn;
          if (ramp_dn == '0) state_d = CLOSED;
        end
      end
      default: state_d = CLOSED;
    endcase
    busy_d = (state_d == OPENING) || (state_d == CLOSING);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLOSED;
      pos_q   <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
    end
  end

  assign pos   = pos_q;
  assign state = state_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_door_sequencer.sv
module tb_door_sequencer;

  localparam int F    = 100;
  localparam int PMIN = 10;
  localparam int SPAN = 40;
  localparam int HOLD = 3;

`ifdef OBSTACLE_REOPEN_EN
  localparam int OBS_ST  = 1;
  localparam int OBS_POS = 40;
`else
  localparam int OBS_ST  = 3;
  localparam int OBS_POS = 20;
`endif

  // Expected pos/state after each of the first 11 frame ticks of an open cycle.
  int exp_pa[11] = '{10, 20, 30, 40, 40, 40, 40, 30, 20, 10, 0};
  int exp_sa[11] = '{ 1,  1,  1,  2,  2,  2,  3,  3,  3,  3, 0};
  int exp_pb[11] = '{15, 30, 40, 40, 40, 40, 25, 10,  0,  0, 0};
  int exp_sb[11] = '{ 1,  1,  2,  2,  2,  3,  3,  3,  0,  0, 0};

  int    stp[2] = '{10, 15};
  string nm[2]  = '{"a", "b"};

  logic clk = 1'b0;
  logic rst = 1'b1, open_req = 1'b0, close_req = 1'b0, obstacle = 1'b0;
  logic pwm_a, ft_a, busy_a, pwm_b, ft_b, busy_b;
  logic [16:0] pos_a, pos_b;
  logic [1:0]  st_a, st_b;

  always #5 clk = ~clk;

  door_sequencer #(.FRAME_CYCLES(F), .PULSE_MIN(PMIN), .PULSE_SPAN(SPAN),
                   .STEP(10), .HOLD_FRAMES(HOLD)) dut_a (
    .clk(clk), .rst(rst), .open_req(open_req), .close_req(close_req),
    .obstacle(obstacle), .pwm_out(pwm_a), .pos(pos_a), .state(st_a),
    .busy(busy_a), .frame_tick(ft_a));

  door_sequencer #(.FRAME_CYCLES(F), .PULSE_MIN(PMIN), .PULSE_SPAN(SPAN),
                   .STEP(15), .HOLD_FRAMES(HOLD)) dut_b (
    .clk(clk), .rst(rst), .open_req(open_req), .close_req(close_req),
    .obstacle(obstacle), .pwm_out(pwm_b), .pos(pos_b), .state(st_b),
    .busy(busy_b), .frame_tick(ft_b));

  int n_chk = 0, n_fail = 0;
  int m_cnt = 0;
  int m_st[2], m_pos[2], m_hold[2];
  int hi[2], wexp[2];
  bit wvalid = 1'b0;
  bit edge_tick = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: door behaviour per clock edge in plain integer arithmetic.
  task automatic model_edge();
    bit tick, obs;
    tick = (m_cnt == F - 1);
`ifdef OBSTACLE_REOPEN_EN
    obs = obstacle;
`else
    obs = 1'b0;
`endif
    edge_tick = tick && !rst;
    if (rst) begin
      m_cnt = 0;
      for (int k = 0; k < 2; k++) begin
        m_st[k] = 0; m_pos[k] = 0; m_hold[k] = 0;
      end
    end else begin
      m_cnt = tick ? 0 : m_cnt + 1;
      for (int k = 0; k < 2; k++) begin
        case (m_st[k])
          0: if (open_req) m_st[k] = 1;
          1: if (close_req && !open_req) m_st[k] = 3;
             else if (tick) begin
               m_pos[k] = (m_pos[k] + stp[k] > SPAN) ? SPAN : m_pos[k] + stp[k];
               if (m_pos[k] == SPAN) begin m_st[k] = 2; m_hold[k] = HOLD; end
             end
          2: if (open_req || obs) m_hold[k] = HOLD;
             else if (close_req) m_st[k] = 3;
             else if (tick) begin
               m_hold[k] = m_hold[k] - 1;
               if (m_hold[k] <= 0) m_st[k] = 3;
             end
          3: if (open_req || obs) m_st[k] = 1;
             else if (tick) begin
               m_pos[k] = (m_pos[k] > stp[k]) ? m_pos[k] - stp[k] : 0;
               if (m_pos[k] == 0) m_st[k] = 0;
             end
          default: ;
        endcase
      end
    end
  endtask

  task automatic check_outputs(int k, logic [1:0] st, logic [16:0] p, logic b,
                               logic t, logic pw);
    chk({nm[k], ".state"}, 32'(st), m_st[k]);
    chk({nm[k], ".pos"}, 32'(p), m_pos[k]);
    chk({nm[k], ".busy"}, 32'(b), (m_st[k] == 1 || m_st[k] == 3) ? 1 : 0);
    chk({nm[k], ".frame_tick"}, 32'(t), (m_cnt == F - 1) ? 1 : 0);
    if (m_cnt == 0) begin
      chk({nm[k], ".pwm_frame_start"}, 32'(pw), 0);
      hi[k]   = 0;
      wexp[k] = PMIN + m_pos[k];
    end
    if (pw === 1'b1) hi[k]++;
    if (m_cnt == F - 1 && wvalid)
      chk({nm[k], ".pwm_width"}, hi[k], wexp[k]);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    if (m_cnt == 0) wvalid = 1'b1;
    check_outputs(0, st_a, pos_a, busy_a, ft_a, pwm_a);
    check_outputs(1, st_b, pos_b, busy_b, ft_b, pwm_b);
    @(negedge clk);
  endtask

  task automatic next_frame(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!edge_tick && n < 3 * F);
    chk("frame_seen", 32'(edge_tick), 1);
  endtask

  task automatic pulse(bit o, bit c, bit ob);
    open_req = o; close_req = c; obstacle = ob;
    cyc();
    open_req = 1'b0; close_req = 1'b0; obstacle = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset idle
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst.state", 32'(st_a), 0);
    chk("rst.pos", 32'(pos_a), 0);
    chk("rst.busy", 32'(busy_a), 0);
    chk("rst.pwm", 32'(pwm_a), 0);
    rst = 1'b0;
    next_frame(n);
    next_frame(n);
    chk("tick_period", n, F);
    next_frame(n);
    chk("tick_period", n, F);

    // Open / hold / close, both step sizes
    pulse(1, 0, 0);
    chk("open.state_next", 32'(st_a), 1);
    chk("open.busy_next", 32'(busy_a), 1);
    for (int i = 0; i < 11; i++) begin
      next_frame(n);
      chk("ramp_a.pos", 32'(pos_a), exp_pa[i]);
      chk("ramp_a.state", 32'(st_a), exp_sa[i]);
      chk("sat_b.pos", 32'(pos_b), exp_pb[i]);
      chk("sat_b.state", 32'(st_b), exp_sb[i]);
    end

    // Reverse while opening, then open+close together in CLOSED
    pulse(1, 0, 0);
    next_frame(n);
    next_frame(n);
    chk("rev.pos_before", 32'(pos_a), 20);
    pulse(0, 1, 0);
    chk("rev.state", 32'(st_a), 3);
    chk("rev.pos_kept", 32'(pos_a), 20);
    chk("rev.pos_kept_b", 32'(pos_b), 30);
    next_frame(n);
    chk("rev.pos1", 32'(pos_a), 10);
    chk("rev.pos1_b", 32'(pos_b), 15);
    next_frame(n);
    chk("rev.pos2", 32'(pos_a), 0);
    chk("rev.closed", 32'(st_a), 0);
    chk("rev.closed_b", 32'(st_b), 0);
    pulse(1, 1, 0);
    chk("both_req.open_wins", 32'(st_a), 1);
    pulse(0, 1, 0);
    chk("close_at_zero.state", 32'(st_a), 3);
    next_frame(n);
    chk("close_at_zero.closed", 32'(st_a), 0);

    // Obstacle while closing
    pulse(1, 0, 0);
    for (int i = 0; i < 8; i++) next_frame(n);
    chk("obs.pos_before", 32'(pos_a), 30);
    chk("obs.state_before", 32'(st_a), 3);
    pulse(0, 0, 1);
    chk("obs.state", 32'(st_a), OBS_ST);
    next_frame(n);
    chk("obs.pos_after", 32'(pos_a), OBS_POS);
    for (int i = 0; i < 12; i++) next_frame(n);
    chk("obs.settled_a", 32'(st_a), 0);
    chk("obs.settled_b", 32'(st_b), 0);

    // Reset mid-ramp
    pulse(1, 0, 0);
    next_frame(n);
    next_frame(n);
    chk("midrst.pos_before", 32'(pos_a), 20);
    rst = 1'b1;
    cyc();
    chk("midrst.state", 32'(st_a), 0);
    chk("midrst.pos", 32'(pos_a), 0);
    chk("midrst.pwm", 32'(pwm_a), 0);
    chk("midrst.busy", 32'(busy_a), 0);
    rst = 1'b0;
    next_frame(n);
    next_frame(n);

    // Random requests against the reference model
    for (int i = 0; i < 6000; i++) begin
      open_req  = ($urandom_range(0, 99) < 3);
      close_req = ($urandom_range(0, 99) < 3);
      obstacle  = ($urandom_range(0, 99) < 2);
      rst       = ($urandom_range(0, 1999) == 0);
      cyc();
    end
    open_req = 1'b0; close_req = 1'b0; obstacle = 1'b0; rst = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
